// File: rtl/uart_rx_cfg.sv
// UART receiver: DATA_W data bits LSB first, optional parity, 1/2 stop bits, rdy/clr_rdy handshake.
// Define UART_RX_MAJ3_EN to take each bit as the 3-sample majority instead of a single mid-bit sample.
module uart_rx_cfg #(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic              clr_rdy,
  input  logic [BAUD_W-1:0] DB,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rxs_q;
  logic [BAUD_W-1:0]   cnt_q, cnt_d, db_q, db_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d, rx_data_q, rx_data_d;
  logic                pe_q, pe_d, po_q, po_d, ts_q, ts_d;
  logic                armed_q, armed_d, pbad_q, pbad_d, fbad_q, fbad_d;
  logic                rdy_q, rdy_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                ovr_q, ovr_d;
  logic                sample, bit_v, done;

  assign sample = (cnt_q == '0);

`ifdef UART_RX_MAJ3_EN
  // hist_q[1]/hist_q[0] hold rxs from two and one cycles ago (counter values 2 and 1)
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rxs_q};
  assign bit_v  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end
`else
  assign bit_v = rxs_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    pe_d      = pe_q;
    po_d      = po_q;
    ts_d      = ts_q;
    armed_d   = armed_q;
    pbad_d    = pbad_q;
    fbad_d    = fbad_q;
    done      = 1'b0;

    if (state_q != IDLE) cnt_d = sample ? db_q - BAUD_W'(1) : cnt_q - BAUD_W'(1);

    case (state_q)
      IDLE: begin
        if (rxs_q) armed_d = 1'b1;
        else if (armed_q) begin
          state_d   = START;
          cnt_d     = DB >> 1;
          db_d      = DB;
          pe_d      = parity_en;
          po_d      = parity_odd;
          ts_d      = two_stop;
          bit_cnt_d = '0;
          pbad_d    = 1'b0;
          fbad_d    = 1'b0;
        end
      end
      START: if (sample) state_d = bit_v ? IDLE : DATA;
      DATA: if (sample) begin
        sr_d      = {bit_v, sr_q[DATA_W-1:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_W-1)) state_d = pe_q ? PARITY : STOP1;
      end
      PARITY: if (sample) begin
        pbad_d  = ((^sr_q) ^ bit_v) != po_q;
        state_d = STOP1;
      end
      STOP1: if (sample) begin
        fbad_d = ~bit_v;
        if (ts_q) state_d = STOP2;
        else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      STOP2: if (sample) begin
        fbad_d  = fbad_q | ~bit_v;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a low stop bit disarms so a held break produces a single frame
    if (done && fbad_d) armed_d = 1'b0;

    rx_data_d = done ? sr_d   : rx_data_q;
    par_err_d = done ? pbad_d : par_err_q;
    frm_err_d = done ? fbad_d : frm_err_q;
    rdy_d     = done | (rdy_q & ~clr_rdy);
    ovr_d     = ~clr_rdy & (ovr_q | (done & rdy_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      cnt_q     <= '0;
      db_q      <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      pe_q      <= 1'b0;
      po_q      <= 1'b0;
      ts_q      <= 1'b0;
      armed_q   <= 1'b1;
      pbad_q    <= 1'b0;
      fbad_q    <= 1'b0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      pe_q      <= pe_d;
      po_q      <= po_d;
      ts_q      <= ts_d;
      armed_q   <= armed_d;
      pbad_q    <= pbad_d;
      fbad_q    <= fbad_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_q;
  assign busy    = (state_q != IDLE);

endmodule
